lift_scheduler: RTL and testbench

LIFT_SCHEDULER -- requirements
Module: lift_scheduler

---
 rtl/lift_scheduler.sv | 220 ++++++++++++++++++++++
 tb/tb_lift_scheduler.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lift_scheduler.sv
// lift_scheduler: single-car SCAN scheduler with IDLE / MOVE / DOOR control.
// Optional feature: define LIFT_SCHED_HOME_EN to return an idle car to floor 0
// after HOME_TIMEOUT idle clocks. Without it the car parks where it stopped.
module lift_scheduler #(
  parameter int unsigned NUM_FLOORS    = 8,
  parameter int unsigned TRAVEL_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES   = 3,
  parameter int unsigned HOME_TIMEOUT  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] car_call_i,
  input  logic [NUM_FLOORS-1:0] hall_call_i,
  output logic [2:0]            floor_o,
  output logic [1:0]            dir_o,
  output logic                  door_open_o,
  output logic                  arrive_o,
  output logic                  busy_o,
  output logic [NUM_FLOORS-1:0] pending_o
);

  localparam int unsigned CNT_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DN   = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_t;

  // Reject unsupported configurations at elaboration.
  if (NUM_FLOORS < 2 || NUM_FLOORS > 8 || TRAVEL_CYCLES < 1 || DOOR_CYCLES < 1 ||
      HOME_TIMEOUT < 1) begin : g_param_check
    $error("lift_scheduler: parameter out of range");
  end

  state_t                state_q, state_d;
  logic [2:0]            floor_q, floor_d;
  logic [1:0]            dir_q, dir_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic                  arrive_q, arrive_d;
  logic                  door_q, door_d;
  logic                  busy_q, busy_d;

  logic [NUM_FLOORS-1:0] req_c;
  logic [NUM_FLOORS-1:0] clear_c;
  logic [2:0]            step_floor_c;
  logic [1:0]            rev_dir_c;
  logic [1:0]            nxt_dir_c;
  logic                  homing_c;

`ifdef LIFT_SCHED_HOME_EN
  localparam int unsigned HOME_W = $clog2(HOME_TIMEOUT + 1);
  logic              home_q, home_d;
  logic [HOME_W-1:0] idle_cnt_q, idle_cnt_d;
  assign homing_c = home_q;
`else
  assign homing_c = 1'b0;
`endif

  // True when a request exists strictly beyond fl in direction d.
  function automatic logic ahead(input logic [NUM_FLOORS-1:0] m, input logic [2:0] fl,
                                 input logic [1:0] d);
    logic r;
    r = 1'b0;
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      if (m[i] && (d == DIR_UP) && (3'(i) > fl)) r = 1'b1;
      if (m[i] && (d == DIR_DN) && (3'(i) < fl)) r = 1'b1;
    end
    return r;
  endfunction

  // Direction toward the nearest request other than fl; ties go up.
  function automatic logic [1:0] nearest_dir(input logic [NUM_FLOORS-1:0] m,
                                             input logic [2:0] fl);
    logic [3:0] du;
    logic [3:0] dd;
    du = 4'hF;
    dd = 4'hF;
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      if (m[i] && (3'(i) > fl) && ((4'(i) - 4'(fl)) < du)) du = 4'(i) - 4'(fl);
      if (m[i] && (3'(i) < fl) && ((4'(fl) - 4'(i)) < dd)) dd = 4'(fl) - 4'(i);
    end
    if (du != 4'hF && du <= dd) return DIR_UP;
    if (dd != 4'hF) return DIR_DN;
    return DIR_IDLE;
  endfunction

  // Next-state, request bookkeeping and output decode.
  always_comb begin
    state_d      = state_q;
    floor_d      = floor_q;
    dir_d        = dir_q;
    cnt_d        = cnt_q;
    arrive_d     = 1'b0;
    clear_c      = '0;
    nxt_dir_c    = DIR_IDLE;
    req_c        = pending_q | car_call_i | hall_call_i;
    step_floor_c = (dir_q == DIR_UP) ? floor_q + 3'd1 : floor_q - 3'd1;
    rev_dir_c    = (dir_q == DIR_UP) ? DIR_DN : DIR_UP;
`ifdef LIFT_SCHED_HOME_EN
    home_d       = home_q;
    idle_cnt_d   = '0;
`endif
    case (state_q)
      S_IDLE: begin
        dir_d = DIR_IDLE;
        if (req_c[floor_q]) begin
          clear_c[floor_q] = 1'b1;
          state_d          = S_DOOR;
          cnt_d            = CNT_W'(DOOR_CYCLES);
          arrive_d         = 1'b1;
        end else if (|req_c) begin
          dir_d   = nearest_dir(req_c, floor_q);
          state_d = S_MOVE;
          cnt_d   = CNT_W'(TRAVEL_CYCLES);
`ifdef LIFT_SCHED_HOME_EN
        end else if (floor_q != 3'd0) begin
          if (idle_cnt_q == HOME_W'(HOME_TIMEOUT - 1)) begin
            dir_d   = DIR_DN;
            state_d = S_MOVE;
            cnt_d   = CNT_W'(TRAVEL_CYCLES);
            home_d  = 1'b1;
          end else begin
            idle_cnt_d = idle_cnt_q + HOME_W'(1);
          end
`endif
        end
      end
      S_MOVE: begin
        if (cnt_q == CNT_W'(1)) begin
          floor_d = step_floor_c;
          cnt_d   = CNT_W'(TRAVEL_CYCLES);
          if (req_c[step_floor_c]) begin
            clear_c[step_floor_c] = 1'b1;
            state_d               = S_DOOR;
            cnt_d                 = CNT_W'(DOOR_CYCLES);
            arrive_d              = 1'b1;
`ifdef LIFT_SCHED_HOME_EN
            home_d                = 1'b0;
`endif
          end else if (!ahead(req_c, step_floor_c, dir_q) &&
                       !(homing_c && step_floor_c != 3'd0)) begin
            state_d = S_IDLE;
            dir_d   = DIR_IDLE;
`ifdef LIFT_SCHED_HOME_EN
            home_d  = 1'b0;
`endif
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DOOR: begin
        if (cnt_q == CNT_W'(1)) begin
          // Departure wins over a same-edge call for this floor; it stays pending.
          if (dir_q == DIR_IDLE)                      nxt_dir_c = nearest_dir(req_c, floor_q);
          else if (ahead(req_c, floor_q, dir_q))      nxt_dir_c = dir_q;
          else if (ahead(req_c, floor_q, rev_dir_c))  nxt_dir_c = rev_dir_c;
          else                                        nxt_dir_c = DIR_IDLE;
          dir_d   = nxt_dir_c;
          state_d = (nxt_dir_c == DIR_IDLE) ? S_IDLE : S_MOVE;
          cnt_d   = CNT_W'(TRAVEL_CYCLES);
        end else if (req_c[floor_q]) begin
          clear_c[floor_q] = 1'b1;
          cnt_d            = CNT_W'(DOOR_CYCLES);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        dir_d   = DIR_IDLE;
      end
    endcase
    pending_d = req_c & ~clear_c;
    door_d    = (state_d == S_DOOR);
    busy_d    = (state_d != S_IDLE) || (|pending_d);
  end

  // State and registered outputs; reset discards all requests immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      floor_q    <= '0;
      dir_q      <= DIR_IDLE;
      cnt_q      <= '0;
      pending_q  <= '0;
      arrive_q   <= 1'b0;
      door_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef LIFT_SCHED_HOME_EN
      home_q     <= 1'b0;
      idle_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      floor_q    <= floor_d;
      dir_q      <= dir_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      arrive_q   <= arrive_d;
      door_q     <= door_d;
      busy_q     <= busy_d;
`ifdef LIFT_SCHED_HOME_EN
      home_q     <= home_d;
      idle_cnt_q <= idle_cnt_d;
`endif
    end
  end

  assign floor_o     = floor_q;
  assign dir_o       = dir_q;
  assign door_open_o = door_q;
  assign arrive_o    = arrive_q;
  assign busy_o      = busy_q;
  assign pending_o   = pending_q;

endmodule

// File: tb/tb_lift_scheduler.sv
// tb_lift_scheduler: directed scenarios for lift_scheduler, checked every cycle
// against a floor/timer model plus hand-computed literal expectations.
module tb_lift_scheduler;

  localparam int NF = 8;
  localparam int TR = 4;
  localparam int DR = 3;
  localparam int HT = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] car_call = 8'h00;
  logic [7:0] hall_call = 8'h00;
  logic [2:0] floor_o;
  logic [1:0] dir_o;
  logic       door_open_o;
  logic       arrive_o;
  logic       busy_o;
  logic [7:0] pending_o;

  int n_pass = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  lift_scheduler #(
    .NUM_FLOORS(NF), .TRAVEL_CYCLES(TR), .DOOR_CYCLES(DR), .HOME_TIMEOUT(HT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .car_call_i(car_call), .hall_call_i(hall_call),
    .floor_o(floor_o), .dir_o(dir_o), .door_open_o(door_open_o),
    .arrive_o(arrive_o), .busy_o(busy_o), .pending_o(pending_o)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 parked, 1 travelling, 2 door open; dir: +1 up, -1 down, 0 none
  int       m_phase = 0;
  int       m_floor = 0;
  int       m_dir = 0;
  int       m_timer = 0;
  int       m_idle = 0;
  bit       m_home = 1'b0;
  bit [7:0] m_pend = 8'h00;
  bit       m_arrive = 1'b0;

  function automatic bit has_dir(input bit [7:0] p, input int f, input int d);
    for (int i = 0; i < NF; i++) if (p[i] && (i - f) * d > 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int nearest(input bit [7:0] p, input int f);
    int du;
    int dd;
    du = 99;
    dd = 99;
    for (int i = 0; i < NF; i++) begin
      if (p[i] && i > f && i - f < du) du = i - f;
      if (p[i] && i < f && f - i < dd) dd = f - i;
    end
    if (du != 99 && du <= dd) return 1;
    if (dd != 99) return -1;
    return 0;
  endfunction

  function automatic int dcode(input int d);
    return (d == 1) ? 1 : ((d == -1) ? 2 : 0);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_floor = 0; m_dir = 0; m_timer = 0; m_idle = 0;
    m_home = 1'b0; m_pend = 8'h00; m_arrive = 1'b0;
  endtask

  task automatic model_step(input bit [7:0] calls);
    bit [7:0] r;
    int nd;
    r = m_pend | calls;
    m_arrive = 1'b0;
    if (m_phase == 0) begin
      m_dir = 0;
      if (r[m_floor]) begin
        r[m_floor] = 1'b0; m_phase = 2; m_timer = 0; m_arrive = 1'b1; m_idle = 0;
      end else if (r != 8'h00) begin
        m_dir = nearest(r, m_floor); m_phase = 1; m_timer = 0; m_idle = 0;
      end else begin
`ifdef LIFT_SCHED_HOME_EN
        if (m_floor != 0) begin
          m_idle++;
          if (m_idle == HT) begin
            m_phase = 1; m_dir = -1; m_home = 1'b1; m_timer = 0; m_idle = 0;
          end
        end else m_idle = 0;
`endif
      end
    end else if (m_phase == 1) begin
      m_timer++;
      if (m_timer == TR) begin
        m_timer = 0;
        m_floor = m_floor + m_dir;
        if (r[m_floor]) begin
          r[m_floor] = 1'b0; m_phase = 2; m_arrive = 1'b1; m_home = 1'b0;
        end else if (!has_dir(r, m_floor, m_dir) && !(m_home && m_floor > 0)) begin
          m_phase = 0; m_dir = 0; m_home = 1'b0;
        end
      end
    end else begin
      m_timer++;
      if (m_timer == DR) begin
        m_timer = 0;
        if (m_dir == 0)                         nd = nearest(r, m_floor);
        else if (has_dir(r, m_floor, m_dir))    nd = m_dir;
        else if (has_dir(r, m_floor, -m_dir))   nd = -m_dir;
        else                                    nd = 0;
        m_dir = nd;
        m_phase = (nd == 0) ? 0 : 1;
      end else if (r[m_floor]) begin
        r[m_floor] = 1'b0; m_timer = 0;
      end
    end
    m_pend = r;
  endtask

  // Advance the model on every edge and compare all outputs just after it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else begin
      model_step(car_call | hall_call);
      #1;
      check("floor", int'(floor_o), m_floor);
      check("dir", int'(dir_o), dcode(m_dir));
      check("door", int'(door_open_o), (m_phase == 2) ? 1 : 0);
      check("arrive", int'(arrive_o), int'(m_arrive));
      check("busy", int'(busy_o), (m_phase != 0 || m_pend != 8'h00) ? 1 : 0);
      check("pending", int'(pending_o), int'(m_pend));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_arrive(input int budget, output int cycles);
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      cycles++;
      if (arrive_o) return;
    end
    check("arrive_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (!busy_o) return;
    end
    check("idle_timeout", 0, 1);
  endtask

  task automatic wait_floor(input int f, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (int'(floor_o) == f) return;
    end
    check("floor_timeout", 0, 1);
  endtask

  task automatic pulse(input logic [7:0] car, input logic [7:0] hall);
    @(negedge clk);
    car_call = car;
    hall_call = hall;
    @(negedge clk);
    car_call = 8'h00;
    hall_call = 8'h00;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_floor"}, int'(floor_o), 0);
    check({tag, "_dir"}, int'(dir_o), 0);
    check({tag, "_door"}, int'(door_open_o), 0);
    check({tag, "_arrive"}, int'(arrive_o), 0);
    check({tag, "_busy"}, int'(busy_o), 0);
    check({tag, "_pending"}, int'(pending_o), 0);
  endtask

  initial begin
    int cyc;
    int n;
    int door_n;
    int arr_n;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // single hall call to floor 5 from floor 0
    @(negedge clk);
    hall_call = 8'h20;
    @(posedge clk); #1;
    check("start_dir_up", int'(dir_o), 1);
    check("start_pending", int'(pending_o), 8'h20);
    @(negedge clk);
    hall_call = 8'h00;
    wait_arrive(100, n);
    cyc = 1 + n;
    check("arrive_latency_5", cyc, 1 + 5 * TR);
    check("arrive_floor_5", int'(floor_o), 5);
    door_n = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!door_open_o) break;
      door_n++;
    end
    check("door_cycles_5", door_n, DR);
    check("after_door_dir", int'(dir_o), 0);
    check("after_door_pending", int'(pending_o), 0);
    check("after_door_busy", int'(busy_o), 0);

    // move to floor 2, then a call for the current floor opens the door in place
    pulse(8'h04, 8'h00);
    wait_arrive(100, n);
    check("arrive_floor_2", int'(floor_o), 2);
    wait_idle(20);
    @(negedge clk);
    car_call = 8'h04;
    @(posedge clk); #1;
    check("same_floor_door", int'(door_open_o), 1);
    check("same_floor_arrive", int'(arrive_o), 1);
    check("same_floor_floor", int'(floor_o), 2);
    check("same_floor_dir", int'(dir_o), 0);
    door_n = 1;
    arr_n = 1;
    @(negedge clk);
    car_call = 8'h00;
    @(posedge clk); #1;
    door_n += int'(door_open_o);
    arr_n += int'(arrive_o);
    // hall call for this floor on the second door clock restarts the door count
    @(negedge clk);
    hall_call = 8'h04;
    @(posedge clk); #1;
    door_n += int'(door_open_o);
    arr_n += int'(arrive_o);
    @(negedge clk);
    hall_call = 8'h00;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!door_open_o) break;
      door_n++;
      arr_n += int'(arrive_o);
    end
    check("door_restart_cycles", door_n, 2 + DR);
    check("door_restart_arrivals", arr_n, 1);
    check("door_restart_floor", int'(floor_o), 2);

    // SCAN: up toward 6, calls for 4 (ahead) and 1 (behind) added at floor 3
    wait_idle(20);
    pulse(8'h00, 8'h40);
    wait_floor(3, 100);
    @(negedge clk);
    car_call = 8'h12;
    @(negedge clk);
    car_call = 8'h00;
    wait_arrive(100, n);
    check("scan_stop1_floor", int'(floor_o), 4);
    check("scan_stop1_dir", int'(dir_o), 1);
    wait_arrive(100, n);
    check("scan_stop2_floor", int'(floor_o), 6);
    check("scan_stop2_dir", int'(dir_o), 1);
    wait_arrive(100, n);
    check("scan_stop3_floor", int'(floor_o), 1);
    check("scan_stop3_dir", int'(dir_o), 2);
    wait_idle(20);
    check("scan_end_dir", int'(dir_o), 0);

    // asynchronous reset between floors 3 and 4
    pulse(8'h00, 8'h80);
    wait_floor(3, 100);
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    // call present on the first edge after release is captured
    @(negedge clk);
    car_call = 8'h20;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_pending", int'(pending_o), 8'h20);
    check("post_rst_dir", int'(dir_o), 1);
    @(negedge clk);
    car_call = 8'h00;
    wait_arrive(100, n);
    check("post_rst_floor", int'(floor_o), 5);
    wait_idle(20);

    // long idle at floor 5
    door_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      door_n += int'(door_open_o);
    end
    check("idle_no_door", door_n, 0);
`ifdef LIFT_SCHED_HOME_EN
    check("homed_floor", int'(floor_o), 0);
    check("homed_busy", int'(busy_o), 0);
`else
    check("parked_floor", int'(floor_o), 5);
`endif

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute bound on run time.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
